// File: rtl/dmem_pkg.sv
// Shared state encoding, access-size codes and lane helpers for the data-memory port controller.
// Lane 0 (byte address 0) is the most significant byte, so be[3] enables bits 31:24.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = a[1] ? 4'b0011 : 4'b1100;
            SZ_BYTE: be = 4'b1000 >> a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Reserved size (3) is never legal; halves need an even address, words a zero offset.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        logic ok;
        case (size)
            SZ_WORD: ok = (a == 2'b00);
            SZ_HALF: ok = ~a[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// One-entry posted-write buffer (only built with STORE_BUFFER_EN); drains in the background via mem_req/mem_ack.
// Latency: captured on the push edge, request raised from the next cycle. Backpressure: push only while empty;
// an entry unacked for 2**TIMEOUT_W-1 cycles is discarded with a one-cycle tout.
`ifdef STORE_BUFFER_EN
module dmem_store_buf
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic [31:0] push_data,
    input  logic [3:0]  push_be,
    input  logic        mem_ack,
    output logic        vld,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [3:0]  be,
    output logic        tout
);

    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + TIMEOUT_W'(1);
    assign tout    = vld & ~mem_ack & (&cnt_inc);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld  <= 1'b0;
            addr <= '0;
            data <= '0;
            be   <= '0;
            cnt  <= '0;
        end else if (push) begin
            vld  <= 1'b1;
            addr <= push_addr;
            data <= push_data;
            be   <= push_be;
            cnt  <= '0;
        end else if (vld) begin
            cnt <= cnt_inc;
            if (mem_ack || tout) begin
                vld <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/dmem_port_ctrl.sv
// Turns MEM-stage load/store requests into a req/ack memory access with byte enables (STORE_BUFFER_EN adds posted stores).
// Latency: >=3 cycles request-to-release (2 for a buffered store); BUSY times out after 2**TIMEOUT_W-1 cycles.
// Backpressure: Stall_OUT holds the pipeline until the one-cycle DONE release; mem_req is held until mem_ack.
module dmem_port_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    input  logic [31:0] Address_IN,
    input  logic [31:0] WriteData_IN,
    input  logic [1:0]  WriteSize_IN,
    output logic        Stall_OUT,
    output logic [31:0] ReadData_OUT,
    output logic        Err_OUT,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t state;
    state_t state_nxt;

    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;

    logic        req_q;
    logic        we_q;
    logic        cfl_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;

    logic req_any;
    logic conflict;
    logic legal;
    logic tout;
    logic port_free;
    logic err_in;

    logic start;
    logic fin_ack;
    logic fin_tout;
    logic err_set;

    assign req_any  = MemRead_IN | MemWrite_IN;
    assign conflict = MemRead_IN & MemWrite_IN;
    assign legal    = is_aligned(WriteSize_IN, Address_IN[1:0]);
    assign cnt_inc  = cnt + TIMEOUT_W'(1);
    assign tout     = &cnt_inc;

`ifdef STORE_BUFFER_EN
    logic        sb_push;
    logic        sb_vld;
    logic        sb_tout;
    logic [31:0] sb_addr;
    logic [31:0] sb_data;
    logic [3:0]  sb_be;

    dmem_store_buf #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_store_buf (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (sb_push),
        .push_addr ({Address_IN[31:2], 2'b00}),
        .push_data (WriteData_IN),
        .push_be   (byte_en(WriteSize_IN, Address_IN[1:0])),
        .mem_ack   (mem_ack),
        .vld       (sb_vld),
        .addr      (sb_addr),
        .data      (sb_data),
        .be        (sb_be),
        .tout      (sb_tout)
    );

    // Single memory port: any new access waits while the posted store drains.
    assign port_free = ~sb_vld;
    assign err_in    = err_set | sb_tout;

    assign mem_req   = sb_vld | req_q;
    assign mem_we    = sb_vld ? 1'b1    : we_q;
    assign mem_addr  = sb_vld ? sb_addr : addr_q;
    assign mem_wdata = sb_vld ? sb_data : wdata_q;
    assign mem_be    = sb_vld ? sb_be   : be_q;
`else
    assign port_free = 1'b1;
    assign err_in    = err_set;

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
`endif

    assign ReadData_OUT = rdata_q;
    assign Err_OUT      = err_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Stall_OUT = 1'b0;
        start     = 1'b0;
        fin_ack   = 1'b0;
        fin_tout  = 1'b0;
        err_set   = 1'b0;
`ifdef STORE_BUFFER_EN
        sb_push   = 1'b0;
`endif
        case (state)
            IDLE: begin
                Stall_OUT = req_any;
                if (req_any) begin
                    if (!legal) begin
                        err_set   = 1'b1;
                        state_nxt = DONE;
                    end else if (port_free) begin
`ifdef STORE_BUFFER_EN
                        if (MemWrite_IN) begin
                            sb_push   = 1'b1;
                            err_set   = conflict;
                            state_nxt = DONE;
                        end else begin
                            start     = 1'b1;
                            state_nxt = BUSY;
                        end
`else
                        start     = 1'b1;
                        state_nxt = BUSY;
`endif
                    end
                end
            end
            BUSY: begin
                Stall_OUT = 1'b1;
                // An ack on the final counted cycle still completes cleanly.
                if (mem_ack) begin
                    fin_ack   = 1'b1;
                    err_set   = cfl_q;
                    state_nxt = DONE;
                end else if (tout) begin
                    fin_tout  = 1'b1;
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            cfl_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            err_q <= err_in;
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= MemWrite_IN;
                cfl_q   <= conflict;
                addr_q  <= {Address_IN[31:2], 2'b00};
                wdata_q <= WriteData_IN;
                be_q    <= byte_en(WriteSize_IN, Address_IN[1:0]);
                cnt     <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt_inc;
                if (fin_ack || fin_tout) begin
                    req_q <= 1'b0;
                end
                if (fin_ack && !we_q) begin
                    rdata_q <= mem_rdata;
                end
                if (fin_tout && !we_q) begin
                    rdata_q <= ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Bench for dmem_port_ctrl: directed boundary cases plus randomized accesses against a byte-lane reference model.
module tb_dmem_port_ctrl;

    localparam logic [1:0] SZ_W = 2'd0;
    localparam logic [1:0] SZ_B = 2'd1;
    localparam logic [1:0] SZ_H = 2'd2;
    localparam logic [1:0] SZ_R = 2'd3;
    localparam int         TO_CYCLES = 255;

    logic        CLK          = 1'b0;
    logic        RESET        = 1'b0;
    logic        MemRead_IN   = 1'b0;
    logic        MemWrite_IN  = 1'b0;
    logic [31:0] Address_IN   = 32'h0;
    logic [31:0] WriteData_IN = 32'h0;
    logic [1:0]  WriteSize_IN = 2'd0;
    logic        mem_ack      = 1'b0;
    logic [31:0] mem_rdata    = 32'h0;
    logic        Stall_OUT;
    logic [31:0] ReadData_OUT;
    logic        Err_OUT;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 CLK = ~CLK;

    dmem_port_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MemRead_IN   (MemRead_IN),
        .MemWrite_IN  (MemWrite_IN),
        .Address_IN   (Address_IN),
        .WriteData_IN (WriteData_IN),
        .WriteSize_IN (WriteSize_IN),
        .Stall_OUT    (Stall_OUT),
        .ReadData_OUT (ReadData_OUT),
        .Err_OUT      (Err_OUT),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: an access covers nb consecutive byte lanes starting at the byte offset, lane 0 = be[3].
    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == SZ_W) ? 4 : (sz == SZ_H) ? 2 : 1;
    endfunction

    function automatic logic [3:0] lanes(input int off, input int nb);
        logic [3:0] be;
        be = 4'b0000;
        for (int i = off; i < off + nb && i < 4; i++) begin
            be[3 - i] = 1'b1;
        end
        return be;
    endfunction

    // ack_at: BUSY cycle (1-based) on which memory acks; 0 means never.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [1:0] sz, input int ack_at, input logic [31:0] rdat);
        int         off;
        int         nb;
        int         stall_n;
        int         busy_n;
        int         exp_busy;
        bit         legal;
        bit         released;
        bit         exp_err;
        logic [3:0] be_e;

        off      = int'(addr[1:0]);
        nb       = size_bytes(sz);
        legal    = (sz != SZ_R) && (off % nb == 0);
        be_e     = lanes(off, nb);
        exp_busy = !legal ? 0 : (ack_at == 0) ? TO_CYCLES : ack_at;
        exp_err  = !legal || (rd && wr) || (ack_at == 0);

        @(negedge CLK);
        MemRead_IN   = rd;
        MemWrite_IN  = wr;
        Address_IN   = addr;
        WriteData_IN = wdat;
        WriteSize_IN = sz;
        stall_n      = 0;
        busy_n       = 0;
        released     = 1'b0;
        for (int c = 0; c < 400 && !released; c++) begin
            #1;
            if (!Stall_OUT) begin
                released = 1'b1;
            end else begin
                stall_n++;
                if (mem_req) begin
                    busy_n++;
                    chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    chk("mem_we_be", {27'd0, mem_we, mem_be}, {27'd0, wr, be_e});
                    if (wr) chk("mem_wdata", mem_wdata, wdat);
                    mem_ack   = (busy_n == ack_at);
                    mem_rdata = (busy_n == ack_at) ? rdat : $urandom;
                end else begin
                    // Ack while idle must be ignored.
                    mem_ack   = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
                @(negedge CLK);
                mem_ack = 1'b0;
            end
        end
        chk("released", 32'(released), 32'd1);
        chk("stall_cycles", 32'(stall_n), 32'(1 + exp_busy));
        chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
        if (legal && rd && !wr) begin
            exp_rdata = (ack_at == 0) ? 32'hDEADBEEF : rdat;
        end
        chk("err_done", 32'(Err_OUT), 32'(exp_err));
        chk("rdata", ReadData_OUT, exp_rdata);
        chk("req_done", 32'(mem_req), 32'd0);

        // Leave DONE with a stray ack that must not disturb anything.
        MemRead_IN  = 1'b0;
        MemWrite_IN = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = $urandom;
        @(negedge CLK);
        mem_ack = 1'b0;
        #1;
        chk("err_clear", 32'(Err_OUT), 32'd0);
        chk("stall_idle", 32'(Stall_OUT), 32'd0);
        chk("rdata_hold", ReadData_OUT, exp_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         rd;
        bit         wr;
        logic [1:0] sz;
        int         ack_at;

        repeat (3) @(negedge CLK);
        #1;
        chk("rst_req_low", 32'(mem_req), 32'd0);
        RESET = 1'b1;
        #1;
        chk("rst_stall", 32'(Stall_OUT), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_rdata", ReadData_OUT, 32'd0);
        chk("rst_err", 32'(Err_OUT), 32'd0);

        access(1'b1, 1'b0, 32'h100, 32'h0, SZ_W, 4, 32'h1234_5678);
        access(1'b0, 1'b1, 32'h203, 32'h0000_00AB, SZ_B, 1, 32'h0);
        access(1'b0, 1'b1, 32'h301, 32'h0000_1234, SZ_H, 1, 32'h0);
        access(1'b1, 1'b0, 32'h104, 32'h0, SZ_W, 0, 32'h0);
        access(1'b1, 1'b0, 32'h108, 32'h0, SZ_W, TO_CYCLES, 32'hA5A5_5A5A);
        access(1'b1, 1'b0, 32'h102, 32'h0, SZ_W, 1, 32'h1111_1111);
        access(1'b0, 1'b1, 32'h10A, 32'h5555_5555, SZ_W, 1, 32'h0);
        access(1'b1, 1'b0, 32'h10C, 32'h0, SZ_R, 1, 32'h2222_2222);
        access(1'b1, 1'b1, 32'h110, 32'hCAFE_F00D, SZ_H, 2, 32'h3333_3333);
        access(1'b1, 1'b0, 32'h112, 32'h0, SZ_H, 3, 32'h4444_4444);
        access(1'b1, 1'b0, 32'h115, 32'h0, SZ_B, 2, 32'h6666_6666);

        // Reset in the middle of BUSY abandons the access at once.
        @(negedge CLK);
        MemRead_IN   = 1'b1;
        MemWrite_IN  = 1'b0;
        Address_IN   = 32'h500;
        WriteSize_IN = SZ_W;
        repeat (3) @(negedge CLK);
        #1;
        chk("req_before_rst", 32'(mem_req), 32'd1);
        RESET      = 1'b0;
        MemRead_IN = 1'b0;
        #1;
        chk("rst_busy_req", 32'(mem_req), 32'd0);
        chk("rst_busy_stall", 32'(Stall_OUT), 32'd0);
        chk("rst_busy_rdata", ReadData_OUT, 32'd0);
        exp_rdata = 32'h0;
        @(negedge CLK);
        RESET = 1'b1;
        access(1'b1, 1'b0, 32'h500, 32'h0, SZ_W, 2, 32'h7777_8888);

        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            sz     = 2'($urandom_range(0, 3));
            ack_at = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
            access(rd, wr, $urandom, $urandom, sz, ack_at, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
